// File: rtl/axi_mem_pkg.sv
// Shared AXI encodings, FSM state types and helpers for the burst RAM slave.
package axi_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_burst_ram_slave_if.sv
// AXI4 burst channel bundle (AW/W/B/AR/R) between a master and the RAM slave.
interface axi_burst_ram_slave_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arlen, arburst, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );

  modport master (
    output awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           araddr, arlen, arburst, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts, plus illegal-burst detection.
module axi_burst_addr_gen import axi_mem_pkg::*; #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned STEP   = 4
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              illegal
);
  localparam int unsigned SHIFT = clog2(STEP);

  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    incr      = addr + ADDR_W'(STEP);
    // Wrap window is (len+1) beats; only power-of-two windows are legal.
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << SHIFT) - ADDR_W'(1);
    next_addr = addr;
    illegal   = 1'b0;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr;
      BURST_WRAP: begin
        next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
        illegal   = !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
      end
      default:     illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/axi_burst_ram_slave.sv
// AXI4 burst RAM slave: byte-strobed writes, latency-programmable reads, SLVERR
// on range/burst errors, round-robin sharing of the single-port array.
module axi_burst_ram_slave import axi_mem_pkg::*; #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       RD_LAT    = 1
) (
  input logic               clk,
  input logic               rst,
  axi_burst_ram_slave_if.slave s
);
  localparam int unsigned STEP  = DATA_W / 8;
  localparam int unsigned SHIFT = clog2(STEP);
  localparam int unsigned IDX_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int unsigned LAT_W = 4;

  logic [DATA_W-1:0] mem [DEPTH];

  w_state_t          w_state;
  logic [ADDR_W-1:0] waddr, w_next;
  logic [7:0]        wlen, wcnt;
  logic [1:0]        wburst, bresp;
  logic              werr, awready, bvalid, w_illegal;

  r_state_t          r_state;
  logic [ADDR_W-1:0] raddr, r_next;
  logic [7:0]        rlen, rcnt;
  logic [1:0]        rburst, rresp;
  logic [LAT_W-1:0]  rwait;
  logic              r_issued, arready, rvalid, rlast, r_illegal;
  logic [DATA_W-1:0] rdata;

  logic pri_w;
  logic w_req_c, r_req_c, w_grant_c, r_grant_c, w_ok_c, r_ok_c, w_last_c;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] diff;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    return !diff[ADDR_W] && ((diff[ADDR_W-1:0] >> SHIFT) < ADDR_W'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> SHIFT);
  endfunction

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .STEP(STEP)) u_wgen (
    .addr(waddr), .len(wlen), .burst(wburst), .next_addr(w_next), .illegal(w_illegal)
  );

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .STEP(STEP)) u_rgen (
    .addr(raddr), .len(rlen), .burst(rburst), .next_addr(r_next), .illegal(r_illegal)
  );

  // One array access per cycle; contested cycles alternate owner.
  assign w_req_c   = (w_state == W_DATA) && s.wvalid;
  assign r_req_c   = (r_state == R_DATA) && !r_issued && (!rvalid || s.rready);
  assign w_grant_c = w_req_c && (!r_req_c || pri_w);
  assign r_grant_c = r_req_c && !w_grant_c;
  assign w_ok_c    = !w_illegal && in_range(waddr);
  assign r_ok_c    = !r_illegal && in_range(raddr);
  assign w_last_c  = (wcnt == wlen);

  assign s.awready = awready;
  assign s.wready  = w_grant_c;
  assign s.bvalid  = bvalid;
  assign s.bresp   = bresp;
  assign s.arready = arready;
  assign s.rvalid  = rvalid;
  assign s.rdata   = rdata;
  assign s.rresp   = rresp;
  assign s.rlast   = rlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     pri_w <= 1'b1;
    else if (w_req_c && r_req_c) pri_w <= !w_grant_c;
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (w_grant_c && w_ok_c) begin
      for (int unsigned b = 0; b < STEP; b++) begin
        if (s.wstrb[b]) mem[word_idx(waddr)][8*b +: 8] <= s.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      waddr   <= '0;
      wlen    <= '0;
      wburst  <= BURST_FIXED;
      wcnt    <= '0;
      werr    <= 1'b0;
      awready <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (s.awvalid && awready) begin
            awready <= 1'b0;
            waddr   <= s.awaddr;
            wlen    <= s.awlen;
            wburst  <= s.awburst;
            wcnt    <= '0;
            werr    <= 1'b0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_grant_c) begin
            waddr <= w_next;
            wcnt  <= wcnt + 8'd1;
            // Beat count ends the burst; a misplaced WLAST only poisons BRESP.
            if (w_last_c) begin
              bvalid  <= 1'b1;
              bresp   <= (werr || !w_ok_c || !s.wlast) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              werr <= werr || !w_ok_c || s.wlast;
            end
          end
        end
        W_RESP: begin
          if (s.bready) begin
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= R_IDLE;
      raddr    <= '0;
      rlen     <= '0;
      rburst   <= BURST_FIXED;
      rcnt     <= '0;
      rwait    <= '0;
      r_issued <= 1'b0;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
      rlast    <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (s.arvalid && arready) begin
            arready  <= 1'b0;
            raddr    <= s.araddr;
            rlen     <= s.arlen;
            rburst   <= s.arburst;
            rcnt     <= '0;
            r_issued <= 1'b0;
            rwait    <= LAT_W'((RD_LAT == 0) ? 0 : RD_LAT - 1);
            r_state  <= (RD_LAT == 0) ? R_DATA : R_WAIT;
          end
        end
        R_WAIT: begin
          if (rwait == '0) r_state <= R_DATA;
          else             rwait   <= rwait - LAT_W'(1);
        end
        R_DATA: begin
          if (r_grant_c) begin
            rvalid <= 1'b1;
            rdata  <= r_ok_c ? mem[word_idx(raddr)] : '0;
            rresp  <= r_ok_c ? RESP_OKAY : RESP_SLVERR;
            rlast  <= (rcnt == rlen);
            rcnt   <= rcnt + 8'd1;
            raddr  <= r_next;
            if (rcnt == rlen) r_issued <= 1'b1;
          end else if (rvalid && s.rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if (r_issued) begin
              arready <= 1'b1;
              r_state <= R_IDLE;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_burst_ram_slave.sv
// Directed scoreboard bench for axi_burst_ram_slave (DATA_W=32, DEPTH=256, RD_LAT=3).
module tb_axi_burst_ram_slave;
  localparam int unsigned RD_LAT = 3;
  localparam int          TMO    = 200;
  localparam logic [1:0]  FIXED  = 2'b00;
  localparam logic [1:0]  INCR   = 2'b01;
  localparam logic [1:0]  WRAP   = 2'b10;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  axi_burst_ram_slave_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  axi_burst_ram_slave #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(256), .BASE_ADDR(32'h0), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .s(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ctl"}, 32'({bus.awready, bus.wready, bus.bvalid, bus.bresp,
                            bus.arready, bus.rvalid, bus.rresp, bus.rlast}), 32'd0);
    chk({tag, "_rdata"}, bus.rdata, 32'd0);
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] r, input logic l);
    exp_t e;
    e.data = d; e.resp = r; e.last = l;
    exp_q.push_back(e);
  endtask

  // All drivers start and end at posedge+1; handshakes are decided at negedge.
  task automatic do_aw(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
    int n;
    n = 0;
    bus.awaddr = a; bus.awlen = l; bus.awburst = b; bus.awvalid = 1'b1;
    @(negedge clk);
    while (!bus.awready && n < TMO) begin @(negedge clk); n++; end
    chk("aw_timeout", 32'(n >= TMO), 32'd0);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b);
    int n;
    n = 0;
    bus.araddr = a; bus.arlen = l; bus.arburst = b; bus.arvalid = 1'b1;
    @(negedge clk);
    while (!bus.arready && n < TMO) begin @(negedge clk); n++; end
    chk("ar_timeout", 32'(n >= TMO), 32'd0);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                             input logic [31:0] d0, input logic [3:0] strb,
                             input bit early_last, input logic [1:0] exp_resp);
    int n;
    do_aw(a, l, b);
    for (int i = 0; i <= int'(l); i++) begin
      bus.wdata  = d0 + 32'(i);
      bus.wstrb  = strb;
      bus.wlast  = early_last ? (i == 0) : (i == int'(l));
      bus.wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.wready && n < TMO) begin @(negedge clk); n++; end
      chk("w_timeout", 32'(n >= TMO), 32'd0);
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.bvalid && n < TMO) begin @(negedge clk); n++; end
    chk("b_timeout", 32'(n >= TMO), 32'd0);
    chk("bresp", 32'(bus.bresp), 32'(exp_resp));
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  // Pops one scoreboard entry per R handshake; optionally stalls the first beat.
  task automatic read_burst(input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                            input int stall, input int exp_lat);
    int   n, got, sc, first;
    bit   done;
    exp_t e;
    n = 0; got = 0; sc = 0; first = 0; done = 0;
    do_ar(a, l, b);
    bus.rready = (stall == 0);
    while (!done && n < TMO) begin
      @(negedge clk);
      n++;
      if (bus.rvalid) begin
        if (first == 0) begin
          first = n;
          if (exp_lat != 0) chk("r_latency", 32'(n - 1), 32'(exp_lat));
        end
        if (exp_q.size() == 0) begin
          chk("r_unexpected_beat", 32'd1, 32'd0);
          done = 1;
        end else if (bus.rready) begin
          e = exp_q.pop_front();
          chk("rdata", bus.rdata, e.data);
          chk("rresp", 32'(bus.rresp), 32'(e.resp));
          chk("rlast", 32'(bus.rlast), 32'(e.last));
          got++;
          if (got == int'(l) + 1) done = 1;
        end else begin
          chk("r_stall_rdata", bus.rdata, exp_q[0].data);
          sc++;
        end
      end
      @(posedge clk); #1;
      bus.rready = (sc >= stall);
    end
    chk("r_timeout", 32'(!done), 32'd0);
    bus.rready = 1'b0;
  endtask

  initial begin
    bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state
    #1;
    chk_idle_outputs("reset");
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // INCR write and read-back, with uncontended first-beat latency
    write_burst(32'h10, 8'd3, INCR, 32'd1, 4'hF, 1'b0, OKAY);
    for (int i = 1; i <= 4; i++) push(32'(i), OKAY, i == 4);
    read_burst(32'h10, 8'd3, INCR, 0, RD_LAT + 1);

    // Byte strobes
    write_burst(32'h20, 8'd0, INCR, 32'hAABBCCDD, 4'hF, 1'b0, OKAY);
    write_burst(32'h20, 8'd0, INCR, 32'h11223344, 4'b0101, 1'b0, OKAY);
    push(32'hAA22CC44, OKAY, 1'b1);
    read_burst(32'h20, 8'd0, INCR, 0, 0);

    // WRAP order 0x18,0x1C,0x10,0x14 and illegal WRAP length
    push(32'd3, OKAY, 1'b0); push(32'd4, OKAY, 1'b0);
    push(32'd1, OKAY, 1'b0); push(32'd2, OKAY, 1'b1);
    read_burst(32'h18, 8'd3, WRAP, 0, 0);
    push(32'd0, SLVERR, 1'b0); push(32'd0, SLVERR, 1'b0); push(32'd0, SLVERR, 1'b1);
    read_burst(32'h18, 8'd2, WRAP, 0, 0);

    // Reserved burst type writes nothing
    write_burst(32'h30, 8'd0, INCR, 32'hCAFEF00D, 4'hF, 1'b0, OKAY);
    write_burst(32'h30, 8'd0, 2'b11, 32'hDEADBEEF, 4'hF, 1'b0, SLVERR);
    push(32'hCAFEF00D, OKAY, 1'b1);
    read_burst(32'h30, 8'd0, INCR, 0, 0);

    // WLAST on the wrong beat
    write_burst(32'h34, 8'd1, INCR, 32'h100, 4'hF, 1'b1, SLVERR);

    // FIXED burst: every beat lands on the same word
    write_burst(32'h60, 8'd2, FIXED, 32'h70, 4'hF, 1'b0, OKAY);
    push(32'h72, OKAY, 1'b0); push(32'h72, OKAY, 1'b1);
    read_burst(32'h60, 8'd1, FIXED, 0, 0);

    // Latency plus five stalled cycles with RDATA held
    for (int i = 1; i <= 4; i++) push(32'(i), OKAY, i == 4);
    read_burst(32'h10, 8'd3, INCR, 5, RD_LAT + 1);

    // Burst crossing the top of the array
    write_burst(32'h3FC, 8'd1, INCR, 32'h55AA0001, 4'hF, 1'b0, SLVERR);
    push(32'h55AA0001, OKAY, 1'b0); push(32'd0, SLVERR, 1'b1);
    read_burst(32'h3FC, 8'd1, INCR, 0, 0);

    // Concurrent 8-beat read and write bursts
    write_burst(32'h40, 8'd7, INCR, 32'h400, 4'hF, 1'b0, OKAY);
    for (int i = 0; i < 8; i++) push(32'h400 + 32'(i), OKAY, i == 7);
    fork
      write_burst(32'h80, 8'd7, INCR, 32'h800, 4'hF, 1'b0, OKAY);
      read_burst(32'h40, 8'd7, INCR, 0, 0);
    join
    for (int i = 0; i < 8; i++) push(32'h800 + 32'(i), OKAY, i == 7);
    read_burst(32'h80, 8'd7, INCR, 0, 0);

    // Reset in the middle of a read burst
    do_ar(32'h40, 8'd7, INCR);
    bus.rready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk_idle_outputs("mid_reset");
    bus.rready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("q_empty_after_reset", 32'(exp_q.size()), 32'd0);

    // Contents survive reset and new bursts complete normally
    for (int i = 1; i <= 4; i++) push(32'(i), OKAY, i == 4);
    read_burst(32'h10, 8'd3, INCR, 0, RD_LAT + 1);
    write_burst(32'h50, 8'd0, INCR, 32'h5A5A5A5A, 4'hF, 1'b0, OKAY);
    push(32'h5A5A5A5A, OKAY, 1'b1);
    read_burst(32'h50, 8'd0, INCR, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
